// File: rtl/zuc_pkg.sv
// Shared helpers for the ZUC stream fabric.
package zuc_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/zuc_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping to 0.
module zuc_rr_pick #(
  parameter int nreq = 4,
  parameter int idw  = 2
) (
  input  logic [nreq-1:0] req,
  input  logic [idw-1:0]  ptr,
  output logic [nreq-1:0] onehot,
  output logic [idw-1:0]  idx,
  output logic            any
);

  // Outer loop walks priority distance, inner loop finds the requester at that distance.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= nreq; k++) begin
      for (int i = 0; i < nreq; i++) begin
        if (!any && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + nreq))) begin
          any       = 1'b1;
          onehot[i] = 1'b1;
          idx       = idw'(i);
        end
      end
    end
  end

endmodule

// File: rtl/zuc_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding one shared stream pipeline
// through a single registered output stage.
module zuc_stream_arbiter
  import zuc_pkg::*;
#(
  parameter int dw   = 32,
  parameter int nreq = 4,
  parameter int idw  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [nreq-1:0]    s_valid,
  output logic [nreq-1:0]    s_ready,
  input  logic [nreq*dw-1:0] s_data,
  input  logic [nreq-1:0]    s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [dw-1:0]      m_data,
  output logic               m_last,
  output logic [idw-1:0]     m_id,
  output logic [nreq-1:0]    grant
);

  if (idw != clog2(nreq)) begin : g_bad_idw
    $error("zuc_stream_arbiter: idw must equal clog2(nreq)");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [idw-1:0]  ptr;
  logic [idw-1:0]  owner;
  logic [nreq-1:0] pick_oh;
  logic [idw-1:0]  pick_idx;
  logic            pick_any;
  logic            out_free;
  logic            own_fire;
  logic [dw-1:0]   own_data;
  logic            own_last;

  zuc_rr_pick #(.nreq(nreq), .idw(idw)) u_pick (
    .req    (s_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign out_free = !m_valid || m_ready;
  assign s_ready  = (state == LOCKED && out_free) ? grant : '0;
  assign own_fire = |(s_valid & s_ready);

  // Mux the owner's beat using the one-hot grant rather than an index.
  always_comb begin
    own_data = '0;
    own_last = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      if (grant[i]) begin
        own_data = s_data[i*dw +: dw];
        own_last = s_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr     <= idw'(nreq - 1);
      owner   <= '0;
      grant   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (own_fire)
        m_valid <= 1'b1;
      else if (m_ready)
        m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= LOCKED;
            grant <= pick_oh;
            owner <= pick_idx;
          end
        end
        LOCKED: begin
          // Releasing on the last accepted beat forces one IDLE cycle between packets.
          if (own_fire && own_last) begin
            state <= IDLE;
            ptr   <= owner;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload is meaningful only under m_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (own_fire) begin
      m_data <= own_data;
      m_last <= own_last;
      m_id   <= owner;
    end
  end

endmodule

// File: tb/tb_zuc_stream_arbiter.sv
// Scoreboard bench for zuc_stream_arbiter: per-requester beat FIFOs plus
// directed arbitration checks and a random stress phase.
module tb_zuc_stream_arbiter;

  localparam int DW   = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]    s_valid, s_ready, s_last;
  logic [NREQ*DW-1:0] s_data;
  logic              m_valid, m_ready, m_last;
  logic [DW-1:0]     m_data;
  logic [IDW-1:0]    m_id;
  logic [NREQ-1:0]    grant;

  always #5 clk = ~clk;

  zuc_stream_arbiter #(.dw(DW), .nreq(NREQ), .idw(IDW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_id    (m_id),
    .grant   (grant)
  );

  // Each entry is {last, data}; tx_q feeds the drivers, exp_q is the scoreboard.
  logic [DW:0] tx_q[NREQ][$];
  logic [DW:0] exp_q[NREQ][$];

  int              vprob[NREQ];
  int              mprob;
  logic [NREQ-1:0] hold;
  logic            mr_force;
  logic            mr_val;
  int              nvec;
  int              nerr;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input int r, input int len, input logic [DW-1:0] first, input bit rnd);
    logic [DW:0] beat;
    for (int b = 0; b < len; b++) begin
      beat[DW-1:0] = rnd ? DW'($urandom) : first + DW'(b);
      beat[DW]     = (b == len - 1);
      tx_q[r].push_back(beat);
      exp_q[r].push_back(beat);
    end
  endtask

  task automatic clear_queues();
    for (int r = 0; r < NREQ; r++) begin
      tx_q[r].delete();
      exp_q[r].delete();
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    hold   = '0;
    clear_queues();
    tick();
    tick();
    check_output("reset grant", grant, 0);
    check_output("reset m_valid", m_valid, 0);
    check_output("reset s_ready", s_ready, 0);
    resetn = 1'b1;
  endtask

  function automatic bit busy();
    bit b;
    b = m_valid;
    for (int r = 0; r < NREQ; r++)
      if (tx_q[r].size() != 0 || exp_q[r].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      tick();
      n++;
    end
    if (busy()) begin
      nvec++;
      nerr++;
      $display("[TB] FAIL %s: drain timeout, got busy, expected idle after %0d cycles", name, limit);
    end
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] want);
    int n;
    n = 0;
    while (grant !== want && n < 50) begin
      tick();
      n++;
    end
    if (grant !== want) check_output(name, grant, want);
  endtask

  task automatic wait_m_valid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    if (!m_valid) check_output(name, m_valid, 1);
  endtask

  // Requester and sink drivers: advance a FIFO only after its beat was accepted.
  initial begin
    logic [NREQ-1:0] acc;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      acc = resetn ? (s_valid & s_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
        if (tx_q[i].size() > 0 && !hold[i] && int'($urandom_range(99, 0)) < vprob[i]) begin
          s_valid[i]          = 1'b1;
          s_data[i*DW +: DW]  = tx_q[i][0][DW-1:0];
          s_last[i]           = tx_q[i][0][DW];
        end else begin
          s_valid[i]          = 1'b0;
          s_data[i*DW +: DW]  = DW'($urandom);
          s_last[i]           = 1'($urandom_range(1, 0));
        end
      end
      m_ready = mr_force ? mr_val : (int'($urandom_range(99, 0)) < mprob);
    end
  end

  // Monitor: every m transfer must match the head of its requester's FIFO,
  // and a packet in flight must not be interleaved with another id.
  initial begin
    logic           in_pkt;
    logic [IDW-1:0] cur;
    logic [DW:0]    e;
    in_pkt = 1'b0;
    cur    = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_pkt = 1'b0;
      end else if (m_valid && m_ready) begin
        if (in_pkt) check_output("interleave id", m_id, cur);
        if (exp_q[m_id].size() == 0) begin
          nvec++;
          nerr++;
          $display("[TB] FAIL unexpected beat: got id %0d data %0h, expected no beat", m_id, m_data);
        end else begin
          e = exp_q[m_id].pop_front();
          check_output("beat", {m_last, m_data}, e);
        end
        in_pkt = !m_last;
        cur    = m_id;
      end
    end
  end

  initial begin
    logic [NREQ-1:0] gseq[9];
    int n;
    resetn   = 1'b0;
    mprob    = 100;
    hold     = '0;
    mr_force = 1'b0;
    mr_val   = 1'b1;
    nvec     = 0;
    nerr     = 0;
    for (int r = 0; r < NREQ; r++) vprob[r] = 100;

    // Three-beat packet from requester 0 streams out back to back.
    do_reset();
    apply_stimulus(0, 3, 32'hA, 1'b0);
    wait_m_valid("pkt0 start");
    check_output("pkt0 beat A", {m_id, m_last, m_data}, {2'd0, 1'b0, 32'hA});
    tick();
    check_output("pkt0 beat B", {m_id, m_last, m_data}, {2'd0, 1'b0, 32'hB});
    tick();
    check_output("pkt0 beat C", {m_id, m_last, m_data}, {2'd0, 1'b1, 32'hC});
    check_output("pkt0 C valid", m_valid, 1);
    tick();
    check_output("pkt0 drained", m_valid, 0);
    drain("pkt0", 50);

    // Everyone busy with single-beat packets: strict rotation with an idle gap.
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      apply_stimulus(r, 1, 32'(16 * r + 1), 1'b0);
      apply_stimulus(r, 1, 32'(16 * r + 2), 1'b0);
    end
    gseq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    n = 0;
    while (grant == '0 && n < 50) begin
      tick();
      n++;
    end
    for (int k = 0; k < 9; k++) begin
      check_output($sformatf("rotation step %0d", k), grant, gseq[k]);
      tick();
    end
    drain("rotation", 100);

    // Backpressure mid-packet freezes the output and blocks the owner.
    apply_stimulus(2, 6, 32'h20, 1'b0);
    wait_grant("owner2 grant", 4'b0100);
    wait_m_valid("owner2 start");
    mr_val   = 1'b0;
    mr_force = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_output("stall m_valid", m_valid, 1);
      check_output("stall m_data", m_data, exp_q[2][0][DW-1:0]);
      check_output("stall s_ready2", s_ready[2], 0);
      check_output("stall grant", grant, 4'b0100);
      tick();
    end
    mr_force = 1'b0;
    drain("stall", 100);

    // Owner gap with a competing requester: the lock holds.
    do_reset();
    apply_stimulus(1, 5, 32'h100, 1'b0);
    wait_grant("owner1 grant", 4'b0010);
    apply_stimulus(3, 2, 32'h300, 1'b0);
    hold[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("gap grant", grant, 4'b0010);
      check_output("gap no req3 beat", (m_valid && m_id == 2'd3), 0);
    end
    hold[1] = 1'b0;
    drain("gap", 100);

    // Reset in the middle of a packet drops everything in flight.
    apply_stimulus(2, 4, 32'h200, 1'b0);
    wait_grant("owner2b grant", 4'b0100);
    wait_m_valid("owner2b start");
    resetn = 1'b0;
    clear_queues();
    tick();
    check_output("midreset m_valid", m_valid, 0);
    check_output("midreset grant", grant, 0);
    check_output("midreset s_ready", s_ready, 0);
    resetn = 1'b1;
    for (int r = 0; r < NREQ; r++) apply_stimulus(r, 1, 32'(32'h400 + r), 1'b0);
    n = 0;
    while (grant == '0 && n < 50) begin
      tick();
      n++;
    end
    check_output("post-reset winner", grant, 4'b0001);
    drain("post-reset", 100);

    // Random stress on all requesters and the sink.
    mprob = 70;
    for (int r = 0; r < NREQ; r++) begin
      vprob[r] = int'($urandom_range(100, 30));
      for (int p = 0; p < 8; p++) apply_stimulus(r, int'($urandom_range(5, 1)), '0, 1'b1);
    end
    drain("stress", 4000);
    for (int r = 0; r < NREQ; r++) check_output($sformatf("leftover req%0d", r), exp_q[r].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
